// File: rtl/relu_result_collector_pkg.sv
// -----------------------------------------------------------------------------
// relu_pkg
// Shared definitions for the ReLU result collector:
//   - default geometry (value width, index width, values per row)
//   - row-bank state encoding
//   - helper that sizes the slot pointer (never narrower than one bit)
// -----------------------------------------------------------------------------
package relu_pkg;

    localparam int RELU_DATA_WIDTH  = 32;
    localparam int RELU_INDEX_WIDTH = 34;
    localparam int RELU_CELL_AMOUNT = 2;

    // Lifecycle of one row bank: it is FILLING from the first beat until its
    // last slot is written, then FULL until the downstream handshake empties it.
    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    // Slot pointer width; a single-slot row still needs a one-bit pointer.
    function automatic int slot_ptr_width(input int cells);
        return (cells <= 1) ? 1 : $clog2(cells);
    endfunction

endpackage : relu_pkg

// File: rtl/relu_result_collector_if.sv
// -----------------------------------------------------------------------------
// relu_result_collector_if
// Bundles the collector's stream-in beat signals, the row valid/ready output
// and the two sticky status flags.
//   master : producer/consumer side (drives beats and output_ready)
//   slave  : collector side (drives row data, valid and flags)
// Signals:
//   input_index  [INDEX_WIDTH]            slot index reported by the producer
//   input_value  [DATA_WIDTH]             ReLU value (unsigned)
//   input_enable                          beat valid, no back-pressure
//   output_data  [DATA_WIDTH*CELL_AMOUNT] packed row, slot i at [i*DW +: DW]
//   output_valid                          row available
//   output_ready                          downstream accepts the row
//   overflow                              sticky: a beat was dropped
//   index_error                           sticky: input_index mismatched slot
// -----------------------------------------------------------------------------
interface relu_result_collector_if #(
    parameter int DATA_WIDTH  = relu_pkg::RELU_DATA_WIDTH,
    parameter int INDEX_WIDTH = relu_pkg::RELU_INDEX_WIDTH,
    parameter int CELL_AMOUNT = relu_pkg::RELU_CELL_AMOUNT
);

    logic [INDEX_WIDTH-1:0]            input_index;
    logic [DATA_WIDTH-1:0]             input_value;
    logic                              input_enable;
    logic [DATA_WIDTH*CELL_AMOUNT-1:0] output_data;
    logic                              output_valid;
    logic                              output_ready;
    logic                              overflow;
    logic                              index_error;

    modport master (
        output input_index,
        output input_value,
        output input_enable,
        output output_ready,
        input  output_data,
        input  output_valid,
        input  overflow,
        input  index_error
    );

    modport slave (
        input  input_index,
        input  input_value,
        input  input_enable,
        input  output_ready,
        output output_data,
        output output_valid,
        output overflow,
        output index_error
    );

endinterface : relu_result_collector_if

// File: rtl/relu_row_bank.sv
// -----------------------------------------------------------------------------
// relu_row_bank
// One row buffer of CELL_AMOUNT values with a single write port addressed by
// slot, a whole-row clear and a packed read-out.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   wr_en_i        write wr_data_i into slot wr_slot_i
//   wr_slot_i      slot to write
//   wr_data_i      value to write
//   clear_i        zero the whole row (takes priority over a write)
//   row_o          packed row, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module relu_row_bank
    import relu_pkg::*;
#(
    parameter int DATA_WIDTH  = RELU_DATA_WIDTH,
    parameter int CELL_AMOUNT = RELU_CELL_AMOUNT,
    parameter int PTR_WIDTH   = slot_ptr_width(RELU_CELL_AMOUNT)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              wr_en_i,
    input  logic [PTR_WIDTH-1:0]              wr_slot_i,
    input  logic [DATA_WIDTH-1:0]             wr_data_i,
    input  logic                              clear_i,
    output logic [DATA_WIDTH*CELL_AMOUNT-1:0] row_o
);

    logic [DATA_WIDTH-1:0] slot_q [CELL_AMOUNT];
    logic [DATA_WIDTH-1:0] slot_d [CELL_AMOUNT];

    always_comb begin
        // NOTE: every combinational output starts from a full default so no
        // path leaves it unassigned and no latch is inferred.
        slot_d = slot_q;
        for (int i = 0; i < CELL_AMOUNT; i++) begin
            if (clear_i) begin
                slot_d[i] = '0;
            end else if (wr_en_i && (wr_slot_i == PTR_WIDTH'(i))) begin
                slot_d[i] = wr_data_i;
            end
        end
    end

    // NOTE: the row storage is reset as well; it is only CELL_AMOUNT words and a
    // defined value after reset keeps the read path free of X.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CELL_AMOUNT; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            slot_q <= slot_d;
        end
    end

    for (genvar g = 0; g < CELL_AMOUNT; g++) begin : g_pack
        assign row_o[g*DATA_WIDTH +: DATA_WIDTH] = slot_q[g];
    end

endmodule : relu_row_bank

// File: rtl/relu_result_collector.sv
// -----------------------------------------------------------------------------
// relu_result_collector
// Sink of the relu_cell output stream. Consecutive accepted beats are packed
// into rows of CELL_AMOUNT values; completed rows are offered downstream over a
// valid/ready handshake. Two row banks work ping-pong so that collection keeps
// going while the downstream stalls on one finished row.
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset; discards every partial/full row
//   bus       relu_result_collector_if.slave (beats in, rows out, sticky flags)
// Notes:
//   - The slot a value lands in always comes from the internal pointer; the
//     producer's input_index is only compared against it.
//   - Accept/drop is decided from the bank states before the edge, so a beat
//     arriving while both banks are full is dropped even if a handshake frees
//     a bank in that same edge.
// -----------------------------------------------------------------------------
module relu_result_collector
    import relu_pkg::*;
#(
    parameter int DATA_WIDTH  = RELU_DATA_WIDTH,
    parameter int INDEX_WIDTH = RELU_INDEX_WIDTH,
    parameter int CELL_AMOUNT = RELU_CELL_AMOUNT
) (
    input logic                    clk,
    input logic                    reset_n,
    relu_result_collector_if.slave bus
);

    localparam int                   PTR_WIDTH = slot_ptr_width(CELL_AMOUNT);
    localparam int                   ROW_WIDTH = DATA_WIDTH * CELL_AMOUNT;
    localparam logic [PTR_WIDTH-1:0] LAST_SLOT = PTR_WIDTH'(CELL_AMOUNT - 1);

    bank_state_e            bank_state_q [2];
    bank_state_e            bank_state_d [2];
    logic [PTR_WIDTH-1:0]   ptr_q,         ptr_d;
    logic                   wr_bank_q,     wr_bank_d;
    logic                   rd_bank_q,     rd_bank_d;
    logic                   overflow_q,    overflow_d;
    logic                   index_error_q, index_error_d;

    logic [1:0]             full_count;
    logic                   row_valid;
    logic                   accept;
    logic                   handshake;
    logic [1:0]             bank_wr_en;
    logic [1:0]             bank_clear;
    logic [ROW_WIDTH-1:0]   bank_row [2];

    // ------------------------------------------------------------------
    // Status derived from the registered bank states
    // ------------------------------------------------------------------
    assign full_count = 2'(bank_state_q[0] == BANK_FULL)
                      + 2'(bank_state_q[1] == BANK_FULL);
    assign row_valid  = (full_count != 2'd0);
    assign accept     = bus.input_enable && (full_count != 2'd2);
    assign handshake  = row_valid && bus.output_ready;

    // The write bank is never FULL while a beat is accepted and the read bank
    // is FULL whenever a handshake happens, so the two ports never collide.
    always_comb begin
        bank_wr_en = '0;
        bank_clear = '0;
        bank_wr_en[wr_bank_q] = accept;
        bank_clear[rd_bank_q] = handshake;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        bank_state_d  = bank_state_q;
        ptr_d         = ptr_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        overflow_d    = overflow_q;
        index_error_d = index_error_q;

        if (handshake) begin
            bank_state_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d               = ~rd_bank_q;
        end

        if (accept) begin
            if (bus.input_index != INDEX_WIDTH'(ptr_q)) begin
                index_error_d = 1'b1;
            end
            if (ptr_q == LAST_SLOT) begin
                bank_state_d[wr_bank_q] = BANK_FULL;
                ptr_d                   = '0;
                wr_bank_d               = ~wr_bank_q;
            end else begin
                bank_state_d[wr_bank_q] = BANK_FILLING;
                ptr_d                   = ptr_q + PTR_WIDTH'(1);
            end
        end else if (bus.input_enable) begin
            overflow_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_state_q[0] <= BANK_EMPTY;
            bank_state_q[1] <= BANK_EMPTY;
            ptr_q           <= '0;
            wr_bank_q       <= 1'b0;
            rd_bank_q       <= 1'b0;
            overflow_q      <= 1'b0;
            index_error_q   <= 1'b0;
        end else begin
            bank_state_q    <= bank_state_d;
            ptr_q           <= ptr_d;
            wr_bank_q       <= wr_bank_d;
            rd_bank_q       <= rd_bank_d;
            overflow_q      <= overflow_d;
            index_error_q   <= index_error_d;
        end
    end

    // ------------------------------------------------------------------
    // Row banks
    // ------------------------------------------------------------------
    for (genvar b = 0; b < 2; b++) begin : g_bank
        relu_row_bank #(
            .DATA_WIDTH  (DATA_WIDTH),
            .CELL_AMOUNT (CELL_AMOUNT),
            .PTR_WIDTH   (PTR_WIDTH)
        ) u_bank (
            .clk       (clk),
            .reset_n   (reset_n),
            .wr_en_i   (bank_wr_en[b]),
            .wr_slot_i (ptr_q),
            .wr_data_i (bus.input_value),
            .clear_i   (bank_clear[b]),
            .row_o     (bank_row[b])
        );
    end

    // ------------------------------------------------------------------
    // Outputs: straight from registers through the read-bank mux; a FULL
    // read bank is never written, so the row holds steady during a stall.
    // ------------------------------------------------------------------
    assign bus.output_valid = row_valid;
    assign bus.output_data  = row_valid ? bank_row[rd_bank_q] : '0;
    assign bus.overflow     = overflow_q;
    assign bus.index_error  = index_error_q;

endmodule : relu_result_collector

// File: tb/tb_relu_result_collector.sv
// -----------------------------------------------------------------------------
// tb_relu_result_collector
// Self-checking bench for relu_result_collector (DATA_WIDTH=32, CELL_AMOUNT=2):
// directed sequences, a stall/overflow vector table and a randomized run
// against a row-queue reference model.
// -----------------------------------------------------------------------------
module tb_relu_result_collector;
    import relu_pkg::*;

    localparam int DW = 32;
    localparam int IW = 34;
    localparam int CA = 2;
    localparam int RW = DW * CA;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    relu_result_collector_if #(
        .DATA_WIDTH (DW),
        .INDEX_WIDTH(IW),
        .CELL_AMOUNT(CA)
    ) bus ();

    relu_result_collector #(
        .DATA_WIDTH (DW),
        .INDEX_WIDTH(IW),
        .CELL_AMOUNT(CA)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input bit v, input logic [RW-1:0] d,
                             input bit ovf, input bit ie);
        check({tag, " valid"}, RW'(bus.output_valid), RW'(v));
        if (v) check({tag, " data"}, bus.output_data, d);
        check({tag, " overflow"}, RW'(bus.overflow), RW'(ovf));
        check({tag, " index_error"}, RW'(bus.index_error), RW'(ie));
    endtask

    // One clock: apply inputs, take the edge, settle 1 time unit after it.
    task automatic cycle(input bit en, input logic [IW-1:0] idx,
                         input logic [DW-1:0] val, input bit rdy);
        bus.input_enable = en;
        bus.input_index  = idx;
        bus.input_value  = val;
        bus.output_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.input_enable = 1'b0;
        bus.input_index  = '0;
        bus.input_value  = '0;
        bus.output_ready = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of finished rows plus the row being built.
    // ------------------------------------------------------------------
    logic [RW-1:0] m_rows [$];
    logic [DW-1:0] m_part [CA];
    int            m_cnt;
    bit            m_ovf;
    bit            m_ie;

    task automatic model_reset();
        m_rows.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        m_ie  = 1'b0;
    endtask

    task automatic model_step(input bit en, input logic [IW-1:0] idx,
                              input logic [DW-1:0] val, input bit rdy);
        bit            room;
        logic [RW-1:0] row;
        room = (m_rows.size() < 2);
        if (m_rows.size() > 0 && rdy) void'(m_rows.pop_front());
        if (en && room) begin
            if (idx != IW'(m_cnt)) m_ie = 1'b1;
            m_part[m_cnt] = val;
            m_cnt++;
            if (m_cnt == CA) begin
                for (int i = 0; i < CA; i++) row[i*DW +: DW] = m_part[i];
                m_rows.push_back(row);
                m_cnt = 0;
            end
        end else if (en) begin
            m_ovf = 1'b1;
        end
    endtask

    // ------------------------------------------------------------------
    // Stall / overflow vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit            en;
        logic [IW-1:0] idx;
        logic [DW-1:0] val;
        bit            rdy;
        bit            exp_valid;
        logic [RW-1:0] exp_data;
        bit            exp_ovf;
        bit            exp_ie;
    } vec_t;

    vec_t stall_tab [9];

    initial begin
        bus.input_enable = 1'b0;
        bus.input_index  = '0;
        bus.input_value  = '0;
        bus.output_ready = 1'b0;

        stall_tab[0] = '{1'b1, 34'd0, 32'd1, 1'b0, 1'b0, 64'h0,                 1'b0, 1'b0};
        stall_tab[1] = '{1'b1, 34'd1, 32'd2, 1'b0, 1'b1, 64'h00000002_00000001, 1'b0, 1'b0};
        stall_tab[2] = '{1'b1, 34'd0, 32'd3, 1'b0, 1'b1, 64'h00000002_00000001, 1'b0, 1'b0};
        stall_tab[3] = '{1'b1, 34'd1, 32'd4, 1'b0, 1'b1, 64'h00000002_00000001, 1'b0, 1'b0};
        stall_tab[4] = '{1'b1, 34'd0, 32'd5, 1'b0, 1'b1, 64'h00000002_00000001, 1'b1, 1'b0};
        stall_tab[5] = '{1'b1, 34'd1, 32'd6, 1'b0, 1'b1, 64'h00000002_00000001, 1'b1, 1'b0};
        stall_tab[6] = '{1'b0, 34'd0, 32'd0, 1'b1, 1'b1, 64'h00000004_00000003, 1'b1, 1'b0};
        stall_tab[7] = '{1'b0, 34'd0, 32'd0, 1'b1, 1'b0, 64'h0,                 1'b1, 1'b0};
        stall_tab[8] = '{1'b0, 34'd0, 32'd0, 1'b1, 1'b0, 64'h0,                 1'b1, 1'b0};

        // Reset values while reset_n is held low
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset data", bus.output_data, '0);
        check_out("reset", 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Basic row with downstream ready
        cycle(1'b1, 34'd0, 32'd5, 1'b1);
        check_out("basic beat0", 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 34'd1, 32'd7, 1'b1);
        check_out("basic row", 1'b1, 64'h00000007_00000005, 1'b0, 1'b0);
        cycle(1'b0, 34'd0, 32'd0, 1'b1);
        check_out("basic drained", 1'b0, '0, 1'b0, 1'b0);

        // Index mismatch: value still placed by internal pointer
        cycle(1'b1, 34'd1, 32'd9, 1'b0);
        check_out("idxerr first", 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 34'd0, 32'd8, 1'b0);
        check_out("idxerr row", 1'b1, 64'h00000008_00000009, 1'b0, 1'b1);
        cycle(1'b0, 34'd0, 32'd0, 1'b1);
        check_out("idxerr drained", 1'b0, '0, 1'b0, 1'b1);

        // Stall, overflow and draining of both banks
        do_reset();
        foreach (stall_tab[i]) begin
            cycle(stall_tab[i].en, stall_tab[i].idx, stall_tab[i].val, stall_tab[i].rdy);
            check_out($sformatf("stall[%0d]", i), stall_tab[i].exp_valid,
                      stall_tab[i].exp_data, stall_tab[i].exp_ovf, stall_tab[i].exp_ie);
        end

        // Asynchronous reset mid-cycle discards a full and a partial row
        do_reset();
        cycle(1'b1, 34'd0, 32'd1, 1'b0);
        cycle(1'b1, 34'd1, 32'd2, 1'b0);
        check_out("async pre full", 1'b1, 64'h00000002_00000001, 1'b0, 1'b0);
        cycle(1'b1, 34'd0, 32'd3, 1'b0);
        bus.input_enable = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check("async data", bus.output_data, '0);
        check_out("async in reset", 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle(1'b1, 34'd0, 32'd1, 1'b0);
        check_out("async after beat0", 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 34'd1, 32'd2, 1'b0);
        check_out("async after row", 1'b1, 64'h00000002_00000001, 1'b0, 1'b0);

        // Completion and handshake in the same edge: no bubble
        do_reset();
        cycle(1'b1, 34'd0, 32'd10, 1'b0);
        cycle(1'b1, 34'd1, 32'd11, 1'b0);
        cycle(1'b1, 34'd0, 32'd12, 1'b0);
        check_out("same-edge A held", 1'b1, 64'h0000000B_0000000A, 1'b0, 1'b0);
        cycle(1'b1, 34'd1, 32'd13, 1'b1);
        check_out("same-edge B shown", 1'b1, 64'h0000000D_0000000C, 1'b0, 1'b0);
        cycle(1'b0, 34'd0, 32'd0, 1'b0);
        check_out("same-edge B held", 1'b1, 64'h0000000D_0000000C, 1'b0, 1'b0);
        cycle(1'b0, 34'd0, 32'd0, 1'b1);
        check_out("same-edge drained", 1'b0, '0, 1'b0, 1'b0);

        // Both banks full, handshake frees one in the same edge as a beat: dropped
        cycle(1'b1, 34'd0, 32'd21, 1'b0);
        cycle(1'b1, 34'd1, 32'd22, 1'b0);
        cycle(1'b1, 34'd0, 32'd23, 1'b0);
        cycle(1'b1, 34'd1, 32'd24, 1'b0);
        cycle(1'b1, 34'd0, 32'd25, 1'b1);
        check_out("drop on free", 1'b1, 64'h00000018_00000017, 1'b1, 1'b0);
        // Dropped beat left the pointer at slot 0
        cycle(1'b1, 34'd0, 32'd26, 1'b0);
        cycle(1'b1, 34'd1, 32'd27, 1'b1);
        check_out("after drop row", 1'b1, 64'h0000001B_0000001A, 1'b1, 1'b0);

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            bit            en;
            bit            rdy;
            logic [IW-1:0] idx;
            logic [DW-1:0] val;
            int unsigned   ready_pct;
            ready_pct = (((n / 500) % 3) == 0) ? 20 : (((n / 500) % 3) == 1) ? 50 : 90;
            en  = ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < ready_pct);
            val = $urandom;
            idx = IW'(m_cnt);
            if (m_rows.size() < 2 && $urandom_range(0, 299) == 0) idx = IW'({$urandom, $urandom});
            cycle(en, idx, val, rdy);
            model_step(en, idx, val, rdy);
            check_out($sformatf("rand[%0d]", n), (m_rows.size() > 0),
                      (m_rows.size() > 0) ? m_rows[0] : '0, m_ovf, m_ie);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_relu_result_collector
